// File: rtl/mem8x8_ctrl_pkg.sv
// Shared definitions for the mem8x8 access controller: default widths,
// bytecell op encodings, grant encodings and FSM state encodings.
`timescale 1ns/1ps
package mem8x8_ctrl_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/mem8x8_ctrl_rr_arb2.sv
// Two-way arbiter for the mem8x8 controller.
// Default: round-robin, simultaneous requests go to the side not granted last.
// MEM_CTRL_FIXED_PRIO_EN: fixed priority, A always wins, last_grant ignored.
`timescale 1ns/1ps
module rr_arb2
    import mem8x8_ctrl_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic gnt_a,
    output logic gnt_b
);

`ifdef MEM_CTRL_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // A has absolute priority over B
    always_comb begin
        gnt_a = req_a;
        gnt_b = req_b & ~req_a;
    end
`else
    // single request wins outright; a tie goes to whoever was not served last
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (req_a && req_b) begin
            gnt_a = (last_grant == GRANT_B);
            gnt_b = (last_grant == GRANT_A);
        end else begin
            gnt_a = req_a;
            gnt_b = req_b;
        end
    end
`endif

endmodule

// File: rtl/mem8x8_ctrl.sv
// Two-port access controller for the 8x8 bytecell array. Arbitrates A/B,
// sequences op/inp around a one-hot sel pulse and captures read data.
// Arbitration mode selected by MEM_CTRL_FIXED_PRIO_EN (see rr_arb2).
//
// state  | meaning
// IDLE   | sel=0, op=read; waits for a request, latches winner's command
// SETUP  | op/inp driven from latched command, sel still low
// ACCESS | sel=1<<addr for ACCESS_CYC cycles; read data captured on last one
// HOLD   | sel dropped, op/inp still held
// DONE   | winner's ack pulse; op back to read, inp back to 0
`timescale 1ns/1ps
module mem8x8_ctrl
    import mem8x8_ctrl_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int ACCESS_CYC = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a_req,
    input  logic                   a_we,
    input  logic [ADDR_W-1:0]      a_addr,
    input  logic [DATA_W-1:0]      a_wdata,
    output logic                   a_ack,
    input  logic                   b_req,
    input  logic                   b_we,
    input  logic [ADDR_W-1:0]      b_addr,
    input  logic [DATA_W-1:0]      b_wdata,
    output logic                   b_ack,
    output logic [DATA_W-1:0]      rdata,
    output logic                   busy,
    output logic [(1<<ADDR_W)-1:0] mem_sel,
    output logic                   mem_op,
    output logic [DATA_W-1:0]      mem_inp,
    input  logic [DATA_W-1:0]      mem_outp
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYC - 1);

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic                cmd_we;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic                winner;
    logic                last_grant;
    logic                gnt_a, gnt_b;
    logic                any_req;
    logic                access_last;

    assign any_req     = a_req | b_req;
    assign access_last = (state == ST_ACCESS) && (cnt == 4'd0);

    rr_arb2 u_arb (
        .req_a      (a_req),
        .req_b      (b_req),
        .last_grant (last_grant),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // command latch, grant history, access down-counter and read capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 4'd0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            winner     <= GRANT_A;
            last_grant <= GRANT_B;
            rdata      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        winner     <= gnt_b ? GRANT_B : GRANT_A;
                        last_grant <= gnt_b ? GRANT_B : GRANT_A;
                        cmd_we     <= gnt_b ? b_we    : a_we;
                        cmd_addr   <= gnt_b ? b_addr  : a_addr;
                        cmd_wdata  <= gnt_b ? b_wdata : a_wdata;
                    end
                end
                ST_SETUP: cnt <= CNT_LOAD;
                ST_ACCESS: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    if (access_last && !cmd_we) rdata <= mem_outp;
                end
                default: ;
            endcase
        end
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (any_req) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: if (access_last) state_nxt = ST_HOLD;
            ST_HOLD:   state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // memory bus and handshake outputs; op/inp framed around the sel pulse
    always_comb begin
        mem_sel = '0;
        mem_op  = OP_READ;
        mem_inp = '0;
        a_ack   = 1'b0;
        b_ack   = 1'b0;
        case (state)
            ST_SETUP, ST_ACCESS, ST_HOLD: begin
                mem_op  = cmd_we ? OP_WRITE : OP_READ;
                mem_inp = cmd_we ? cmd_wdata : '0;
                if (state == ST_ACCESS)
                    mem_sel = {{(DEPTH-1){1'b0}}, 1'b1} << cmd_addr;
            end
            ST_DONE: begin
                a_ack = (winner == GRANT_A);
                b_ack = (winner == GRANT_B);
            end
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mem8x8_ctrl.sv
`timescale 1ns/1ps
module tb_mem8x8_ctrl;
    import mem8x8_ctrl_pkg::*;

    localparam int AC = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [2:0] a_addr = 0, b_addr = 0;
    logic [7:0] a_wdata = 0, b_wdata = 0;
    logic       a_ack, b_ack, busy, mem_op;
    logic [7:0] rdata, mem_sel, mem_inp, mem_outp;

    int tests = 0;
    int fails = 0;

    mem8x8_ctrl #(.DATA_W(8), .ADDR_W(3), .ACCESS_CYC(AC)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
        .rdata(rdata), .busy(busy), .mem_sel(mem_sel), .mem_op(mem_op),
        .mem_inp(mem_inp), .mem_outp(mem_outp)
    );

    always #5 clk = ~clk;

    // bytecell array model
    logic [7:0] mem [8] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_op == OP_WRITE)
            for (int i = 0; i < 8; i++)
                if (mem_sel[i]) mem[i] <= mem_inp;
    end
    always_comb begin
        mem_outp = 8'h00;
        for (int i = 0; i < 8; i++)
            if (mem_sel[i]) mem_outp = mem[i];
    end

    // bus monitor: sel one-hot/zero, op/inp stable around the sel pulse
    logic [7:0] prev_sel = 0, prev_inp = 0;
    logic       prev_op = 1;
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            tests++;
            if (!$onehot0(mem_sel)) begin
                fails++;
                $display("FAIL sel_onehot: mem_sel=%b", mem_sel);
            end
            if ((mem_sel != 0 || prev_sel != 0) && (mem_op != prev_op || mem_inp != prev_inp)) begin
                fails++;
                $display("FAIL bus_stable: op %b->%b inp %h->%h", prev_op, mem_op, prev_inp, mem_inp);
            end
            prev_sel = mem_sel; prev_op = mem_op; prev_inp = mem_inp;
        end else begin
            prev_sel = 0; prev_op = 1; prev_inp = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       who;
        logic [7:0] rdata;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic       who;
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    task automatic set_req(input logic who, input logic req, input logic we,
                           input logic [2:0] addr, input logic [7:0] wdata);
        if (who == GRANT_A) begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
        end else begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
        end
    endtask

    task automatic check_ack_against_sb(input string tag);
        sb_t e;
        check({tag, "_both_ack"}, {31'd0, a_ack & b_ack}, 0);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_who"}, {31'd0, b_ack}, {31'd0, e.who});
            check({tag, "_rdata"}, {24'd0, rdata}, {24'd0, e.rdata});
        end
    endtask

    // one transfer from a single requester; checks latency, sel pulse, ack and rdata
    task automatic do_xfer(input logic who, input logic we, input logic [2:0] addr,
                           input logic [7:0] wdata, input logic [7:0] exp_rdata);
        sb_t e;
        int cyc, hits;
        logic got;
        logic [7:0] exp_sel;
        exp_sel = 8'h01 << addr;
        @(negedge clk);
        e.who = who; e.rdata = exp_rdata;
        sb_q.push_back(e);
        set_req(who, 1'b1, we, addr, wdata);
        cyc = 0; hits = 0; got = 0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (mem_sel == exp_sel) hits++;
            else if (mem_sel != 0) begin
                fails++;
                $display("FAIL sel_addr: mem_sel=%b expected %b", mem_sel, exp_sel);
            end
            if (a_ack || b_ack) got = 1;
        end
        check("ack_seen", {31'd0, got}, 1);
        if (got) begin
            check_ack_against_sb("xfer");
            check("latency", cyc, 3 + AC);
            check("sel_cycles", hits, AC);
        end else begin
            void'(sb_q.pop_front());
        end
        set_req(who, 1'b0, we, addr, wdata);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0;
        a_req = 0; b_req = 0;
        repeat (2) @(negedge clk);
        check("rst_sel", {24'd0, mem_sel}, 0);
        check("rst_op", {31'd0, mem_op}, 1);
        check("rst_inp", {24'd0, mem_inp}, 0);
        check("rst_rdata", {24'd0, rdata}, 0);
        check("rst_ack", {30'd0, a_ack, b_ack}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        rst_n = 1;
    endtask

    vec_t vecs[9];
    logic [7:0] last_rd;

    initial begin
        vecs[0] = '{GRANT_A, 1'b1, 3'd3, 8'hAA, 8'h00};
        vecs[1] = '{GRANT_A, 1'b0, 3'd3, 8'h00, 8'hAA};
        vecs[2] = '{GRANT_B, 1'b1, 3'd7, 8'hC3, 8'hAA};
        vecs[3] = '{GRANT_A, 1'b0, 3'd0, 8'h00, 8'h00};
        vecs[4] = '{GRANT_A, 1'b0, 3'd7, 8'h00, 8'hC3};
        vecs[5] = '{GRANT_B, 1'b1, 3'd2, 8'h55, 8'hC3};
        vecs[6] = '{GRANT_A, 1'b0, 3'd2, 8'h00, 8'h55};
        vecs[7] = '{GRANT_B, 1'b1, 3'd5, 8'hF0, 8'h55};
        vecs[8] = '{GRANT_B, 1'b0, 3'd5, 8'h00, 8'hF0};

        apply_reset();

        for (int i = 0; i < 9; i++)
            do_xfer(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

        // fill every cell with a walking one and read it back
        last_rd = 8'hF0;
        for (int i = 0; i < 8; i++)
            do_xfer(i[0], 1'b1, 3'(i), 8'h01 << i, last_rd);
        for (int i = 0; i < 8; i++) begin
            do_xfer(~i[0], 1'b0, 3'(i), 8'h00, 8'h01 << i);
            last_rd = 8'h01 << i;
        end

        // both requesters held high through four transfers
        begin
            sb_t e;
            int n, cyc;
            apply_reset();
            for (int k = 0; k < 4; k++) begin
`ifdef MEM_CTRL_FIXED_PRIO_EN
                e.who = GRANT_A;
`else
                e.who = (k % 2 == 0) ? GRANT_A : GRANT_B;
`endif
                e.rdata = (e.who == GRANT_A) ? 8'h08 : 8'h80;
                sb_q.push_back(e);
            end
            @(negedge clk);
            set_req(GRANT_A, 1'b1, 1'b0, 3'd3, 8'h00);
            set_req(GRANT_B, 1'b1, 1'b0, 3'd7, 8'h00);
            n = 0; cyc = 0;
            while (n < 4 && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (a_ack || b_ack) begin
                    check_ack_against_sb("arb");
                    n++;
                end
            end
            check("arb_count", n, 4);
            a_req = 0; b_req = 0;
            sb_q.delete();
        end

        // reset asserted while a write is in its ACCESS phase
        begin
            int cyc;
            do_xfer(GRANT_A, 1'b0, 3'd1, 8'h00, 8'h02);
            @(negedge clk);
            set_req(GRANT_A, 1'b1, 1'b1, 3'd4, 8'h77);
            cyc = 0;
            while (mem_sel == 0 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check("abort_reach_access", {24'd0, mem_sel}, 8'h10);
            rst_n = 0;
            #1;
            check("abort_sel", {24'd0, mem_sel}, 0);
            check("abort_busy", {31'd0, busy}, 0);
            a_req = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("abort_no_ack", {30'd0, a_ack, b_ack}, 0);
            end
            rst_n = 1;
            do_xfer(GRANT_A, 1'b1, 3'd4, 8'h99, 8'h00);
            do_xfer(GRANT_B, 1'b0, 3'd4, 8'h00, 8'h99);
        end

        check("sb_drained", sb_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
